// File: rtl/ranger_pkg.sv
// ranger_pkg: shared types and constants for the ultrasonic ranger.
//   state_t      - sequencer FSM state encoding (3-bit)
//   DIST_TIMEOUT - distance value published on any timeout
//   DIST_SAT     - saturation ceiling of the centimetre counter
//   *_W          - counter widths sized for the default 24 MHz timing
//   sat_inc      - saturating increment of the centimetre count
package ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    localparam int unsigned DIST_W   = 16;
    localparam int unsigned PERIOD_W = 21;  // holds PERIOD_CYCLES
    localparam int unsigned PHASE_W  = 20;  // holds TRIG_CYCLES / TIMEOUT_CYCLES
    localparam int unsigned SUB_W    = 11;  // holds CYCLES_PER_CM
    localparam int unsigned AVG_W    = 18;  // sum of four distances

    localparam logic [DIST_W-1:0] DIST_TIMEOUT = 16'hFFFF;
    localparam logic [DIST_W-1:0] DIST_SAT     = 16'hFFFE;

    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        return (v >= DIST_SAT) ? DIST_SAT : v + 16'd1;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync: brings the asynchronous sensor echo into the clk domain and
// produces single-cycle edge pulses.
//   clk, rst_n - system clock, synchronous active-low reset
//   echo       - raw asynchronous echo input
//   rise, fall - one-cycle pulses, the synchronized echo versus its
//                one-cycle delayed copy
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic echo,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= echo;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/ultrasonic_ranger_ctrl.sv
// ultrasonic_ranger_ctrl: HC-SR04 style sequencer. Fires periodic trigger
// pulses, times the echo pulse and publishes the width in whole cm.
//   clk, rst_n - system clock, synchronous active-low reset
//   enable     - run continuous measurements while high
//   echo       - raw asynchronous sensor echo
//   trig       - sensor trigger pulse (registered)
//   distance   - last result in cm, 16'hFFFF on timeout
//   valid      - one-cycle strobe when distance updates
//   timeout    - sticky until the next successful measurement
//   busy       - high whenever the sequencer is not idle
// Build option: RANGER_AVG_EN publishes a 4-sample moving average of the
// successful results instead of the raw value (one extra cycle to valid).
module ultrasonic_ranger_ctrl
    import ranger_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = 240,
    parameter int unsigned CYCLES_PER_CM  = 1392,
    parameter int unsigned TIMEOUT_CYCLES = 912000,
    parameter int unsigned PERIOD_CYCLES  = 1440000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance,
    output logic              valid,
    output logic              timeout,
    output logic              busy
);

    localparam logic [PHASE_W-1:0]  TRIG_LAST   = PHASE_W'(TRIG_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  RISE_LAST   = PHASE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  WIDTH_LIMIT = PHASE_W'(TIMEOUT_CYCLES);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CYCLES - 1);
    localparam logic [SUB_W-1:0]    CM_LAST     = SUB_W'(CYCLES_PER_CM - 1);

    state_t              state;
    state_t              state_next;
    logic [PHASE_W-1:0]  phase_cnt;
    logic [PERIOD_W-1:0] period_cnt;
    logic [SUB_W-1:0]    sub_cnt;
    logic [DIST_W-1:0]   cm_cnt;
    logic [SUB_W-1:0]    sub_step;
    logic [DIST_W-1:0]   cm_step;
    logic                rise;
    logic                fall;
    logic                meas_ok;
    logic                meas_to;
    logic                rise_hit;
    logic                cm_advance;

    echo_sync u_echo_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .echo  (echo),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        meas_ok    = 1'b0;
        meas_to    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_TRIG;
            end
            ST_TRIG: begin
                if (phase_cnt == TRIG_LAST) state_next = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_next = ST_MEASURE;
                end else if (phase_cnt == RISE_LAST) begin
                    meas_to    = 1'b1;
                    state_next = ST_HOLDOFF;
                end
            end
            ST_MEASURE: begin
                if (fall) begin
                    meas_ok    = 1'b1;
                    state_next = ST_HOLDOFF;
                end else if (phase_cnt == WIDTH_LIMIT) begin
                    meas_to    = 1'b1;
                    state_next = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (period_cnt == PERIOD_LAST) begin
                    state_next = enable ? ST_TRIG : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The rise-detect cycle already counts as the first echo-high cycle, so
    // an N-cycle echo accumulates N steps and the result is floor(N / CPC).
    always_comb begin
        rise_hit   = (state == ST_WAIT_RISE) && rise;
        cm_advance = rise_hit || ((state == ST_MEASURE) && (state_next == ST_MEASURE));
        sub_step   = (state == ST_MEASURE) ? sub_cnt : '0;
        cm_step    = (state == ST_MEASURE) ? cm_cnt  : '0;
        if (sub_step == CM_LAST) begin
            sub_step = '0;
            cm_step  = sat_inc(cm_step);
        end else begin
            sub_step = sub_step + SUB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig       <= 1'b0;
            phase_cnt  <= '0;
            period_cnt <= '0;
            sub_cnt    <= '0;
            cm_cnt     <= '0;
        end else begin
            trig <= (state_next == ST_TRIG);

            // In MEASURE phase_cnt is the echo-high width, starting at 1.
            if (rise_hit) begin
                phase_cnt <= PHASE_W'(1);
            end else if (state_next != state) begin
                phase_cnt <= '0;
            end else if (state != ST_IDLE && state != ST_HOLDOFF) begin
                phase_cnt <= phase_cnt + PHASE_W'(1);
            end

            if ((state_next == ST_TRIG && state != ST_TRIG) || state == ST_IDLE) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end

            if (cm_advance) begin
                sub_cnt <= sub_step;
                cm_cnt  <= cm_step;
            end
        end
    end

`ifdef RANGER_AVG_EN
    logic [DIST_W-1:0] hist [4];
    logic              hist_ok;
    logic              avg_pend;
    logic [AVG_W-1:0]  avg_sum;

    always_comb begin
        avg_sum = AVG_W'(hist[0]) + AVG_W'(hist[1]) + AVG_W'(hist[2]) + AVG_W'(hist[3]);
    end

    // History updates on the fall-detect cycle; the average is published
    // one cycle later from the updated history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            distance <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            hist_ok  <= 1'b0;
            avg_pend <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            valid    <= 1'b0;
            avg_pend <= meas_ok;
            if (meas_ok) begin
                hist_ok <= 1'b1;
                if (!hist_ok) begin
                    for (int unsigned i = 0; i < 4; i++) hist[i] <= cm_cnt;
                end else begin
                    hist[0] <= hist[1];
                    hist[1] <= hist[2];
                    hist[2] <= hist[3];
                    hist[3] <= cm_cnt;
                end
            end
            if (meas_to) begin
                distance <= DIST_TIMEOUT;
                valid    <= 1'b1;
                timeout  <= 1'b1;
                hist_ok  <= 1'b0;
            end else if (avg_pend) begin
                distance <= avg_sum[AVG_W-1:2];
                valid    <= 1'b1;
                timeout  <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            distance <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (meas_ok) begin
                distance <= cm_cnt;
                valid    <= 1'b1;
                timeout  <= 1'b0;
            end else if (meas_to) begin
                distance <= DIST_TIMEOUT;
                valid    <= 1'b1;
                timeout  <= 1'b1;
            end
        end
    end
`endif

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// tb_ultrasonic_ranger_ctrl: self-checking bench for ultrasonic_ranger_ctrl
// with short timing parameters. Expected results come from a behavioural
// model of the echo-width-to-centimetre rules (and of the moving average
// when RANGER_AVG_EN is defined).
module tb_ultrasonic_ranger_ctrl;

    localparam int TRIG = 10;
    localparam int CPC  = 4;
    localparam int TO   = 200;
    localparam int PER  = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        echo = 1'b0;
    logic        trig;
    logic [15:0] distance;
    logic        valid;
    logic        timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ultrasonic_ranger_ctrl #(
        .TRIG_CYCLES    (TRIG),
        .CYCLES_PER_CM  (CPC),
        .TIMEOUT_CYCLES (TO),
        .PERIOD_CYCLES  (PER)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .echo     (echo),
        .trig     (trig),
        .distance (distance),
        .valid    (valid),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the inactive edge.
    int          cyc = 0;
    int          trig_rises[$];
    int          fall_cnt = 0;
    int          last_fall_cyc = 0;
    int          valid_cnt = 0;
    int          last_valid_cyc = 0;
    logic [15:0] last_dist = '0;
    logic        last_to = 1'b0;
    logic        trig_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trig === 1'b1 && trig_prev === 1'b0) trig_rises.push_back(cyc);
        if (trig === 1'b0 && trig_prev === 1'b1) begin
            fall_cnt++;
            last_fall_cyc = cyc;
        end
        trig_prev = trig;
        if (valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            last_dist = distance;
            last_to = timeout;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: width 0 means the echo never rose.
    logic [15:0] hist_q[$];

    task automatic model_result(input int width, output logic [15:0] d, output logic to);
        int cm;
        int sum;
        if (width == 0 || width > TO) begin
            d  = 16'hFFFF;
            to = 1'b1;
            hist_q.delete();
        end else begin
            cm = width / CPC;
            if (cm > 65534) cm = 65534;
            to = 1'b0;
`ifdef RANGER_AVG_EN
            if (hist_q.size() == 0) begin
                repeat (4) hist_q.push_back(16'(cm));
            end else begin
                void'(hist_q.pop_front());
                hist_q.push_back(16'(cm));
            end
            sum = 0;
            foreach (hist_q[k]) sum += int'(hist_q[k]);
            d = 16'(sum / 4);
`else
            sum = cm;
            d = 16'(sum);
`endif
        end
    endtask

    task automatic wait_trig_fall(input string tag, output bit ok);
        int f0 = fall_cnt;
        ok = 1'b0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            @(negedge clk); #1;
            if (fall_cnt != f0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s trig_fall: no trig fall seen, required one within 1200 cycles", tag);
        end
    endtask

    task automatic wait_valid(input int v0, input string tag, output bit ok);
        ok = (valid_cnt != v0);
        for (int i = 0; i < 800 && !ok; i++) begin
            @(negedge clk); #1;
            if (valid_cnt != v0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s valid_wait: no valid pulse, required one within 800 cycles", tag);
        end
    endtask

    // One measurement: wait for trig to fall, delay d cycles, drive an echo
    // 'width' cycles long (optionally dropping enable mid-echo), then check
    // the published result against the model.
    task automatic do_measure(input int d, input int width, input int drop_at, input string tag);
        bit          ok;
        int          v0;
        logic [15:0] exp_d;
        logic        exp_to;
        wait_trig_fall(tag, ok);
        if (!ok) return;
        v0 = valid_cnt;
        repeat (d) begin @(negedge clk); #1; end
        if (width > 0) begin
            echo = 1'b1;
            for (int i = 0; i < width; i++) begin
                @(negedge clk); #1;
                if (i + 1 == drop_at) enable = 1'b0;
            end
            echo = 1'b0;
        end
        model_result(width, exp_d, exp_to);
        wait_valid(v0, tag, ok);
        if (!ok) return;
        checks++;
        if (last_dist !== exp_d) begin
            errors++;
            $display("FAIL %s distance (width %0d): got %0d required %0d", tag, width, last_dist, exp_d);
        end
        checks++;
        if (last_to !== exp_to) begin
            errors++;
            $display("FAIL %s timeout (width %0d): got %0b required %0b", tag, width, last_to, exp_to);
        end
    endtask

    task automatic check_spacing(input string tag);
        int n = trig_rises.size();
        checks++;
        if (n < 2) begin
            errors++;
            $display("FAIL %s spacing: only %0d trig rises seen, required at least 2", tag, n);
        end else if (trig_rises[n-1] - trig_rises[n-2] != PER) begin
            errors++;
            $display("FAIL %s spacing: got %0d cycles required %0d", tag,
                     trig_rises[n-1] - trig_rises[n-2], PER);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (trig !== 1'b0)      begin errors++; $display("FAIL reset trig: got %b required 0", trig); end
        checks++; if (distance !== 16'h0) begin errors++; $display("FAIL reset distance: got %h required 0000", distance); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset valid: got %b required 0", valid); end
        checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL reset timeout: got %b required 0", timeout); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
        repeat (5) @(negedge clk); #1;
        checks++; if (trig !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_hold: trig %b busy %b, required 0 0 with enable low", trig, busy);
        end
    endtask

    task automatic test_trig_width();
        int n = 0;
        enable = 1'b1;
        @(negedge clk); #1;
        checks++; if (trig !== 1'b1) begin
            errors++; $display("FAIL trig_start: got %b required 1 one edge after enable", trig);
        end
        while (trig === 1'b1 && n < 50) begin
            checks++; if (distance !== 16'h0 || valid !== 1'b0 || timeout !== 1'b0) begin
                errors++; $display("FAIL trig_outputs: distance %h valid %b timeout %b, required 0000 0 0", distance, valid, timeout);
            end
            n++;
            @(negedge clk); #1;
        end
        checks++; if (n != TRIG) begin
            errors++; $display("FAIL trig_width: got %0d cycles required %0d", n, TRIG);
        end
    endtask

    task automatic test_basic();
        bit          ok;
        int          v0 = valid_cnt;
        logic [15:0] exp_d;
        logic        exp_to;
        echo = 1'b1;
        repeat (41) begin @(negedge clk); #1; end
        echo = 1'b0;
        model_result(41, exp_d, exp_to);
        wait_valid(v0, "basic", ok);
        repeat (10) begin @(negedge clk); #1; end
        checks++; if (last_dist !== exp_d || exp_d !== distance) begin
            errors++; $display("FAIL basic distance: got %0d required %0d", distance, exp_d);
        end
        checks++; if (timeout !== 1'b0) begin
            errors++; $display("FAIL basic timeout: got %b required 0", timeout);
        end
        checks++; if (valid_cnt - v0 != 1) begin
            errors++; $display("FAIL basic valid_pulses: got %0d required 1", valid_cnt - v0);
        end
    endtask

    task automatic test_no_echo();
        do_measure(0, 0, -1, "no_echo");
        checks++; if (last_valid_cyc - last_fall_cyc != TO) begin
            errors++; $display("FAIL no_echo latency: got %0d cycles required %0d", last_valid_cyc - last_fall_cyc, TO);
        end
        do_measure(3, 8, -1, "after_timeout");
    endtask

    task automatic test_width_timeout();
        int r0;
        do_measure(5, 250, -1, "width_timeout");
        r0 = trig_rises.size();
        for (int i = 0; i < 600 && trig_rises.size() == r0; i++) begin
            @(negedge clk); #1;
        end
        check_spacing("width_timeout");
    endtask

    task automatic test_random();
        int d;
        int w;
        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) w = int'($urandom_range(210, 240));
            else                           w = int'($urandom_range(1, 190));
            do_measure(d, w, -1, "random");
            check_spacing("random");
        end
    endtask

    task automatic test_enable_drop();
        int rc;
        int limit;
        do_measure(5, 60, 20, "enable_drop");
        limit = trig_rises[$] + PER + 5;
        for (int i = 0; i < 1000 && cyc < limit; i++) begin
            @(negedge clk); #1;
        end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL enable_drop busy: got %b required 0 after holdoff", busy);
        end
        rc = trig_rises.size();
        repeat (600) begin @(negedge clk); #1; end
        checks++; if (trig_rises.size() != rc || trig !== 1'b0) begin
            errors++; $display("FAIL enable_drop retrigger: got %0d extra trig rises required 0", trig_rises.size() - rc);
        end
    endtask

    task automatic test_reset_mid_trig();
        int r0 = trig_rises.size();
        enable = 1'b1;
        for (int i = 0; i < 10 && trig_rises.size() == r0; i++) begin
            @(negedge clk); #1;
        end
        repeat (3) begin @(negedge clk); #1; end
        checks++; if (trig !== 1'b1) begin
            errors++; $display("FAIL reset_mid setup: trig got %b required 1", trig);
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (trig !== 1'b0) begin
            errors++; $display("FAIL reset_mid trig: got %b required 0", trig);
        end
        checks++; if (busy !== 1'b0 || distance !== 16'h0 || timeout !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid state: busy %b distance %h timeout %b valid %b, required 0 0000 0 0",
                               busy, distance, timeout, valid);
        end
        hist_q.delete();
        rst_n = 1'b1;
    endtask

`ifdef RANGER_AVG_EN
    task automatic test_avg();
        logic [15:0] want [4];
        want[0] = 16'd8; want[1] = 16'd10; want[2] = 16'd14; want[3] = 16'd20;
        for (int i = 0; i < 4; i++) begin
            do_measure(2, 32 * (i + 1), -1, "avg");
            checks++; if (last_dist !== want[i]) begin
                errors++; $display("FAIL avg step %0d: got %0d required %0d", i, last_dist, want[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_trig_width();
        test_basic();
        test_no_echo();
        test_width_timeout();
        test_random();
        test_enable_drop();
        test_reset_mid_trig();
`ifdef RANGER_AVG_EN
        test_avg();
`endif
        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
